button_bank: RTL and testbench



---
 rtl/button_bank_if.sv | 23 ++
 rtl/button_bank.sv | 128 ++++++++++++
 tb/tb_button_bank.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/button_bank_if.sv
// rtl/button_bank_if.sv - button bank signal bundle: raw inputs and clears in, debounced state and events out
interface button_bank_if #(
    parameter int CHANNELS = 8
);
    logic [CHANNELS-1:0] button_in;
    logic [CHANNELS-1:0] clear;
    logic [CHANNELS-1:0] level_out;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] press_sticky;
    logic [CHANNELS-1:0] long_pulse;
    logic                any_press;

    modport master (
        output button_in, clear,
        input  level_out, press_pulse, release_pulse, press_sticky, long_pulse, any_press
    );

    modport slave (
        input  button_in, clear,
        output level_out, press_pulse, release_pulse, press_sticky, long_pulse, any_press
    );
endinterface

// File: rtl/button_bank.sv
// rtl/button_bank.sv - multi-channel bidirectional debouncer with press/release pulses and sticky press flags
// Optional long-press detection is built when BUTTON_BANK_LONGPRESS_EN is defined.
module button_bank #(
    parameter int CHANNELS      = 8,
    parameter int COUNTER_SIZE  = 8,
    parameter int COUNTER_VALUE = 255,
    parameter int SYNC_STAGES   = 2,
    parameter int HOLD_SIZE     = 16,
    parameter int HOLD_VALUE    = 50000
) (
    input logic          clk,
    input logic          reset,
    button_bank_if.slave bb
);

    if (COUNTER_VALUE < 1 || COUNTER_VALUE >= (2 ** COUNTER_SIZE)) begin : g_bad_counter
        $error("button_bank: COUNTER_VALUE must be in 1 .. 2**COUNTER_SIZE-1");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("button_bank: SYNC_STAGES must be >= 1");
    end

    localparam logic [COUNTER_SIZE-1:0] CNT_MAX = COUNTER_SIZE'(COUNTER_VALUE);

    logic [CHANNELS-1:0]     sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0]     s;
    logic [COUNTER_SIZE-1:0] cnt_q  [CHANNELS];
    logic [COUNTER_SIZE-1:0] cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]     level_q, level_d;
    logic [CHANNELS-1:0]     press_q, press_d;
    logic [CHANNELS-1:0]     release_q, release_d;
    logic [CHANNELS-1:0]     sticky_q, sticky_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= bb.button_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Any agreeing cycle restarts the count, so only an uninterrupted run of disagreement is accepted.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i]   = s[i];
                    press_d[i]   = s[i];
                    release_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + COUNTER_SIZE'(1);
                end
            end
        end
        // A press on the same edge as a clear wins so the event is never lost.
        sticky_d = (sticky_q & ~bb.clear) | press_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            sticky_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            sticky_q  <= sticky_d;
        end
    end

`ifdef BUTTON_BANK_LONGPRESS_EN
    if (HOLD_VALUE < 1 || HOLD_VALUE >= (2 ** HOLD_SIZE)) begin : g_bad_hold
        $error("button_bank: HOLD_VALUE must be in 1 .. 2**HOLD_SIZE-1");
    end

    localparam logic [HOLD_SIZE-1:0] HOLD_MAX = HOLD_SIZE'(HOLD_VALUE);

    logic [HOLD_SIZE-1:0] hold_q [CHANNELS];
    logic [HOLD_SIZE-1:0] hold_d [CHANNELS];
    logic [CHANNELS-1:0]  long_q, long_d;

    // The pulse fires only on the cycle the saturating counter first lands on HOLD_MAX.
    always_comb begin
        long_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            hold_d[i] = '0;
            if (level_q[i]) begin
                hold_d[i] = (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + HOLD_SIZE'(1);
            end
            long_d[i] = (hold_d[i] == HOLD_MAX) && (hold_q[i] != HOLD_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) hold_q[i] <= '0;
            long_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) hold_q[i] <= hold_d[i];
            long_q <= long_d;
        end
    end

    assign bb.long_pulse = long_q;
`else
    logic unused_hold_cfg;
    assign unused_hold_cfg = ^{32'(HOLD_SIZE), 32'(HOLD_VALUE)};
    assign bb.long_pulse   = '0;
`endif

    assign bb.level_out     = level_q;
    assign bb.press_pulse   = press_q;
    assign bb.release_pulse = release_q;
    assign bb.press_sticky  = sticky_q;
    assign bb.any_press     = |sticky_q;

endmodule

// File: tb/tb_button_bank.sv
// tb/tb_button_bank.sv - table-driven, scoreboarded bench for button_bank (4 channels, COUNTER_VALUE=3, 2 sync stages)
module tb_button_bank;

    typedef struct {
        logic [3:0] btn;
        logic [3:0] clr;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] stk;
    } vec_t;

    typedef struct {
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] stk;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];
    exp_t exp_q[$];

    button_bank_if #(.CHANNELS(4)) bb ();

    button_bank #(
        .CHANNELS(4), .COUNTER_SIZE(8), .COUNTER_VALUE(3),
        .SYNC_STAGES(2), .HOLD_SIZE(16), .HOLD_VALUE(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bb(bb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int row, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] b, c, l, p, r, s);
        vec_t v;
        v.btn = b; v.clr = c; v.lvl = l; v.prs = p; v.rel = r; v.stk = s;
        vecs.push_back(v);
    endtask

    task automatic hold(input logic [3:0] b, c, l, s, input int n);
        for (int k = 0; k < n; k++) add(b, c, l, 4'b0000, 4'b0000, s);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_lvl"}, 0, bb.level_out, 4'b0000);
        chk({name, "_prs"}, 0, bb.press_pulse, 4'b0000);
        chk({name, "_rel"}, 0, bb.release_pulse, 4'b0000);
        chk({name, "_stk"}, 0, bb.press_sticky, 4'b0000);
        chk({name, "_lng"}, 0, bb.long_pulse, 4'b0000);
        chk({name, "_any"}, 0, {3'b000, bb.any_press}, 4'b0000);
    endtask

    initial begin
        exp_t e;
        vec_t v;
        n_cmp = 0;
        n_bad = 0;

        // Clean press ch0: accepted on the 6th edge after the pin changes.
        hold(4'b0001, 4'b0000, 4'b0000, 4'b0000, 5);
        add (4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
        hold(4'b0001, 4'b0000, 4'b0001, 4'b0001, 1);
        // Bounce ch1: high 3, low 1, then high; one press after 4 consecutive synced highs.
        hold(4'b0011, 4'b0000, 4'b0001, 4'b0001, 3);
        hold(4'b0001, 4'b0000, 4'b0001, 4'b0001, 1);
        hold(4'b0011, 4'b0000, 4'b0001, 4'b0001, 5);
        add (4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0011);
        hold(4'b0011, 4'b0000, 4'b0011, 4'b0011, 2);
        // Press then release ch2; sticky survives the release.
        hold(4'b0111, 4'b0000, 4'b0011, 4'b0011, 5);
        add (4'b0111, 4'b0000, 4'b0111, 4'b0100, 4'b0000, 4'b0111);
        hold(4'b0111, 4'b0000, 4'b0111, 4'b0111, 1);
        hold(4'b0011, 4'b0000, 4'b0111, 4'b0111, 5);
        add (4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0100, 4'b0111);
        hold(4'b0011, 4'b0000, 4'b0011, 4'b0111, 1);
        // Press ch3 with clear on the same edge: set wins; later clear works; repeat clear is a no-op.
        hold(4'b1011, 4'b0000, 4'b0011, 4'b0111, 5);
        add (4'b1011, 4'b1000, 4'b1011, 4'b1000, 4'b0000, 4'b1111);
        hold(4'b1011, 4'b0000, 4'b1011, 4'b1111, 1);
        add (4'b1011, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b0111);
        add (4'b1011, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b0111);
        // Release all held channels together, then clear every sticky flag.
        hold(4'b0000, 4'b0000, 4'b1011, 4'b0111, 5);
        add (4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b0111);
        add (4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // Simultaneous press ch0+ch3, then release ch0 only.
        hold(4'b1001, 4'b0000, 4'b0000, 4'b0000, 5);
        add (4'b1001, 4'b0000, 4'b1001, 4'b1001, 4'b0000, 4'b1001);
        hold(4'b1001, 4'b0000, 4'b1001, 4'b1001, 1);
        hold(4'b1000, 4'b0000, 4'b1001, 4'b1001, 5);
        add (4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b1001);
        hold(4'b1000, 4'b0000, 4'b1000, 4'b1001, 2);

        // Asynchronous reset between edges with random inputs.
        reset        = 1'b0;
        bb.button_in = 4'($urandom);
        bb.clear     = 4'b0000;
        #3 reset = 1'b1;
        #1 check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        bb.button_in = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_release");

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            bb.button_in = v.btn;
            bb.clear     = v.clr;
            e.lvl = v.lvl; e.prs = v.prs; e.rel = v.rel; e.stk = v.stk;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("level_out", k, bb.level_out, e.lvl);
            chk("press_pulse", k, bb.press_pulse, e.prs);
            chk("release_pulse", k, bb.release_pulse, e.rel);
            chk("press_sticky", k, bb.press_sticky, e.stk);
            chk("any_press", k, {3'b000, bb.any_press}, {3'b000, |e.stk});
`ifndef BUTTON_BANK_LONGPRESS_EN
            chk("long_pulse", k, bb.long_pulse, 4'b0000);
`endif
        end
        bb.clear = 4'b0000;

`ifdef BUTTON_BANK_LONGPRESS_EN
        begin
            int waited;
            int first;
            int pulses;
            bb.button_in = 4'b1001;
            waited = 0;
            while (!bb.level_out[0] && waited < 20) begin
                @(posedge clk);
                #1;
                waited++;
            end
            chk("long_level_rise", waited, {3'b000, bb.level_out[0]}, 4'b0001);
            first  = -1;
            pulses = 0;
            for (int n = 1; n <= 30; n++) begin
                @(posedge clk);
                #1;
                if (bb.long_pulse[0]) begin
                    pulses++;
                    if (first < 0) first = n;
                end
                chk("long_other_ch", n, {bb.long_pulse[3:1], 1'b0}, 4'b0000);
            end
            chk("long_delay", 0, 4'(first), 4'd10);
            chk("long_count", 0, 4'(pulses), 4'd1);
        end
`endif

        // Reset asserted mid-count on a fresh press clears everything at once.
        bb.button_in = 4'b0110;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1 check_all_zero("reset_midcount");
        bb.button_in = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1 check_all_zero("reset_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
